// File: rtl/fetch_unit_pkg.sv
// instruction_set: z8 instruction word layout, opcodes and fetch FSM states
package instruction_set;
   localparam int WORD_SIZE   = 16;
   localparam int INSTR_WIDTH = 40;
   localparam int OPC_MSB     = 39;
   localparam int OPC_LSB     = 32;
   localparam logic [OPC_MSB-OPC_LSB:0] OP_NOP  = 8'h00;
   localparam logic [OPC_MSB-OPC_LSB:0] OP_HALT = 8'hFF;
   typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction register with valid/ready handoff to decode
module fetch_unit
   import instruction_set::*;
#(
   parameter int PROG_DEPTH = 256,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [WORD_SIZE-1:0]   pc,
   input  logic [INSTR_WIDTH-1:0] fetch_instr,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [WORD_SIZE-1:0]   instr_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   input  logic                   redirect,
   input  logic [WORD_SIZE-1:0]   redirect_pc,
   output logic                   halted,
   output logic [CNT_WIDTH-1:0]   instr_count
);
   localparam logic [WORD_SIZE-1:0] PC_MASK = WORD_SIZE'(PROG_DEPTH - 1);
   fetch_state_t state, next_state;
   logic [WORD_SIZE-1:0] next_pc;
   logic hs, load, halt_hs, capture, flush;
   // A redirect in the HALT handshake cycle wins: the HALT word is flushed, not obeyed.
   always_comb begin
      hs         = instr_valid && instr_ready;
      load       = !instr_valid || instr_ready;
      halt_hs    = state == RUN && hs && !redirect && instr[OPC_MSB:OPC_LSB] == OP_HALT;
      capture    = state == RUN && load && !redirect && !halt_hs;
      flush      = state == RUN && (redirect || halt_hs);
      next_state = state == BOOT ? RUN : halt_hs ? HALT : state;
      next_pc    = state != RUN ? pc :
                   redirect     ? redirect_pc & PC_MASK :
                   capture      ? (pc + 1'b1) & PC_MASK : pc;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= '0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         instr_count <= '0;
      end else begin
         state       <= next_state;
         pc          <= next_pc;
         halted      <= halted || halt_hs;
         instr_count <= instr_count + CNT_WIDTH'(hs);
         if (capture) begin
            instr       <= fetch_instr;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
         end else if (flush) begin
            instr_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed stimulus, address-stream scoreboard checked by a negedge monitor
module tb_fetch_unit;
   import instruction_set::*;
   logic clk = 0, reset = 1;
   logic [15:0] pc, instr_pc, redirect_pc;
   logic [39:0] fetch_instr, instr;
   logic instr_valid, instr_ready, redirect, halted;
   logic [31:0] instr_count;
   logic [39:0] mem [256];
   typedef struct packed {logic [15:0] a; logic [39:0] w;} exp_t;
   exp_t exp_q[$];
   exp_t e;
   int checks = 0, passes = 0;
   logic exp_halted = 0, prev_hold = 0;
   logic [31:0] hs_cnt = 0;
   logic [39:0] prev_instr;
   logic [15:0] prev_ipc;

   fetch_unit #(.PROG_DEPTH(256), .CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .pc(pc), .fetch_instr(fetch_instr), .instr(instr),
      .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted), .instr_count(instr_count)
   );

   assign fetch_instr = mem[pc[7:0]];
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, want);
   endtask

   task automatic timeout(input string name);
      checks++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Model: after reset/redirect the decode stream is consecutive addresses modulo 256.
   function automatic void push_stream(input int start, input int n);
      for (int i = 0; i < n; i++) begin
         int a = (start + i) % 256;
         exp_q.push_back({16'(a), mem[a]});
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      chk("rst_pc", pc, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_count", instr_count, 0);
   endtask

   task automatic do_redirect(input logic [15:0] t, input logic rdy);
      redirect = 1;
      redirect_pc = t;
      instr_ready = rdy;
      tick();
      redirect = 0;
      exp_q.delete();
      push_stream(int'(t) % 256, 600);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         hs_cnt = 0;
         exp_halted = 0;
         prev_hold = 0;
      end else begin
         if (prev_hold) begin
            chk("hold_instr", instr, prev_instr);
            chk("hold_instr_pc", instr_pc, prev_ipc);
            chk("hold_valid", instr_valid, 1);
         end
         chk("halted", halted, exp_halted);
         chk("instr_count", instr_count, hs_cnt);
         if (exp_halted) chk("halt_valid", instr_valid, 0);
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) timeout("scoreboard_empty");
            else begin
               e = exp_q.pop_front();
               chk("sb_instr_pc", instr_pc, e.a);
               chk("sb_instr", instr, e.w);
               if (e.w[39:32] == OP_HALT && !redirect) exp_halted = 1;
            end
            hs_cnt++;
         end
         prev_hold = instr_valid && !instr_ready && !redirect;
         prev_instr = instr;
         prev_ipc = instr_pc;
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = {8'($urandom_range(0, 254)), 32'($urandom)};
      instr_ready = 0;
      redirect = 0;
      redirect_pc = 0;
      tick();
      exp_q.delete();
      repeat (3) tick();
      check_reset_vals();
      instr_ready = 1;
      reset = 0;
      push_stream(0, 600);
      tick();
      chk("boot_valid", instr_valid, 0);
      chk("boot_pc", pc, 0);
      tick();
      chk("first_valid", instr_valid, 1);
      chk("first_instr_pc", instr_pc, 0);
      chk("first_pc", pc, 1);
      tick();
      chk("seq_instr_pc1", instr_pc, 1);
      tick();
      chk("seq_instr_pc2", instr_pc, 2);
      chk("seq_count2", instr_count, 2);
      instr_ready = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_instr_pc", instr_pc, 2);
         chk("bp_pc", pc, 3);
         chk("bp_count", instr_count, 2);
      end
      instr_ready = 1;
      tick();
      chk("bp_release_instr_pc", instr_pc, 3);
      chk("bp_release_count", instr_count, 3);
      instr_ready = 0;
      tick();
      do_redirect(16'h0040, 0);
      chk("redir_valid", instr_valid, 0);
      chk("redir_pc", pc, 16'h0040);
      instr_ready = 1;
      tick();
      chk("redir_target_pc", instr_pc, 16'h0040);
      chk("redir_target_valid", instr_valid, 1);
      do_redirect(16'd250, 1);
      n = 0;
      while (!(instr_valid && instr_pc == 255) && n < 20) begin tick(); n++; end
      if (n == 20) timeout("wrap_wait");
      tick();
      chk("wrap_instr_pc", instr_pc, 0);
      chk("wrap_valid", instr_valid, 1);
      repeat (1500) begin
         instr_ready = ($urandom % 10) < 7;
         if ($urandom % 40 == 0) do_redirect(16'($urandom), 1'($urandom));
         else tick();
      end
      mem[5] = {OP_HALT, 32'($urandom)};
      instr_ready = 1;
      reset = 1;
      exp_q.delete();
      repeat (3) tick();
      reset = 0;
      push_stream(0, 600);
      n = 0;
      while (!halted && n < 30) begin tick(); n++; end
      if (n == 30) timeout("halt_wait");
      chk("halt_count", instr_count, 6);
      chk("halt_pc", pc, 6);
      chk("halt_valid_low", instr_valid, 0);
      redirect = 1;
      redirect_pc = 16'h0033;
      tick();
      redirect = 0;
      tick();
      chk("halt_redir_pc", pc, 6);
      chk("halt_redir_halted", halted, 1);
      chk("halt_redir_valid", instr_valid, 0);
      reset = 1;
      exp_q.delete();
      tick();
      check_reset_vals();
      tick();
      reset = 0;
      push_stream(0, 600);
      tick();
      chk("restart_pc", pc, 0);
      chk("restart_valid", instr_valid, 0);
      tick();
      chk("restart_first_valid", instr_valid, 1);
      chk("restart_first_pc", instr_pc, 0);
      n = 0;
      while (!(instr_valid && instr_pc == 5) && n < 20) begin tick(); n++; end
      if (n == 20) timeout("halt_addr_wait");
      do_redirect(16'h0180, 1);
      chk("flush_halt_halted", halted, 0);
      chk("flush_halt_valid", instr_valid, 0);
      chk("flush_halt_pc", pc, 16'h0080);
      chk("flush_halt_count", instr_count, 6);
      tick();
      chk("flush_target_pc", instr_pc, 16'h0080);
      chk("flush_target_valid", instr_valid, 1);
      repeat (5) tick();
      chk("mid_valid", instr_valid, 1);
      reset = 1;
      exp_q.delete();
      tick();
      check_reset_vals();
      tick();
      reset = 0;
      push_stream(0, 600);
      tick();
      chk("mid_restart_pc", pc, 0);
      tick();
      chk("mid_restart_valid", instr_valid, 1);
      chk("mid_restart_instr_pc", instr_pc, 0);
      repeat (5) tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
